obi_mem_arbiter: RTL

- Two-master to one-slave OBI arbiter between the core's instruction port (master 0, read-only) and data port (master 1), and one unified memory/interconnect port.
- Arbitrates address phases and tracks outstanding transactions in an in-order route FIFO.
- Steers each response phase back to the master that issued it.
- Sits directly downstream of the core top level; instantiated in the SoC wrapper.

---
 rtl/obi_mem_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/obi_mem_arbiter.sv
// Purpose : two-master (instruction/data) to one-slave OBI arbiter with an in-order route FIFO.
// Latency : zero added cycles on both the request path and the response path (pure steering).
// Backpr. : a full route FIFO holds s_req_o low; a pending slave stall freezes the selected master.
//
// Ports   : imem_* instruction master (read-only), dmem_* data master, s_* unified slave port,
//           spurious_o pulses for one cycle after a response arrives with nothing outstanding.
// Option  : define OBI_ARB_ROUND_ROBIN_EN for round-robin selection instead of data-over-instruction
//           fixed priority.
module obi_mem_arbiter #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned InstrWidth     = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,

    input  logic                   imem_req_i,
    output logic                   imem_gnt_o,
    input  logic [AddrWidth-1:0]   imem_addr_i,
    output logic                   imem_rvalid_o,
    output logic [InstrWidth-1:0]  imem_rdata_o,
    output logic                   imem_err_o,

    input  logic                   dmem_req_i,
    output logic                   dmem_gnt_o,
    input  logic [AddrWidth-1:0]   dmem_addr_i,
    input  logic                   dmem_we_i,
    input  logic [DataWidth-1:0]   dmem_wdata_i,
    input  logic [DataWidth/8-1:0] dmem_be_i,
    output logic                   dmem_rvalid_o,
    output logic [DataWidth-1:0]   dmem_rdata_o,
    output logic                   dmem_err_o,

    output logic                   s_req_o,
    input  logic                   s_gnt_i,
    output logic [AddrWidth-1:0]   s_addr_o,
    output logic                   s_we_o,
    output logic [DataWidth-1:0]   s_wdata_o,
    output logic [DataWidth/8-1:0] s_be_o,
    input  logic                   s_rvalid_i,
    input  logic [DataWidth-1:0]   s_rdata_i,
    input  logic                   s_err_i,

    output logic                   spurious_o
);

    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam bit          Wide     = (DataWidth == 64);

    if (!(DataWidth == 32 || DataWidth == 64)) begin : g_bad_data_width
        $fatal(1, "obi_mem_arbiter: DataWidth must be 32 or 64");
    end
    if (MaxOutstanding < 1) begin : g_bad_depth
        $fatal(1, "obi_mem_arbiter: MaxOutstanding must be >= 1");
    end

    // Route entry: which master owns the response, and which 32-bit half it wants.
    typedef struct packed {
        logic id;
        logic a2;
    } route_t;

    route_t               fifo_q [MaxOutstanding];
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic [CntWidth-1:0]  count_q;
    logic                 lock_q;
    logic                 lock_id_q;
    logic                 spurious_q;
    logic                 full;
    logic                 empty;
    logic                 sel;
    logic                 sel_req;
    logic                 handshake;
    logic                 pop;
    route_t               head;
    route_t               push_entry;
    logic [63:0]          rdata_ext;

`ifdef OBI_ARB_ROUND_ROBIN_EN
    logic                 last_q;
`endif

    assign full  = (count_q == CntWidth'(MaxOutstanding));
    assign empty = (count_q == '0);

    // Selection; while a request is stalled by the slave the choice is frozen so the
    // address phase presented on the slave port cannot change under it.
    always_comb begin
        sel = dmem_req_i;
        if (lock_q) begin
            sel = lock_id_q;
        end else if (imem_req_i && dmem_req_i) begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
            sel = ~last_q;
`else
            sel = 1'b1;
`endif
        end
    end

    assign sel_req = sel ? dmem_req_i : imem_req_i;

    // The full check uses registered occupancy only, so a response cannot unblock a
    // request combinationally. Reset gating keeps grants low during reset.
    assign s_req_o   = rstn_i && sel_req && !full;
    assign handshake = s_req_o && s_gnt_i;

    assign imem_gnt_o = handshake && !sel;
    assign dmem_gnt_o = handshake && sel;

    assign s_addr_o  = sel ? dmem_addr_i  : imem_addr_i;
    assign s_we_o    = sel ? dmem_we_i    : 1'b0;
    assign s_wdata_o = sel ? dmem_wdata_i : '0;
    assign s_be_o    = sel ? dmem_be_i    : '1;

    // The half-select bit is only meaningful on a 64-bit bus; forced to 0 otherwise.
    assign push_entry = '{id: sel, a2: Wide && s_addr_o[2]};

    assign pop  = s_rvalid_i && !empty;
    assign head = fifo_q[rd_ptr_q];

    assign imem_rvalid_o = pop && !head.id;
    assign dmem_rvalid_o = pop && head.id;
    assign imem_err_o    = pop && !head.id && s_err_i;
    assign dmem_err_o    = pop && head.id && s_err_i;

    assign rdata_ext    = 64'(s_rdata_i);
    assign imem_rdata_o = InstrWidth'(head.a2 ? rdata_ext[63:32] : rdata_ext[31:0]);
    assign dmem_rdata_o = s_rdata_i;

    assign spurious_o = spurious_q;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // Entry storage needs no reset: an entry is only read while it is counted.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lock_q     <= 1'b0;
            lock_id_q  <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            if (handshake) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (handshake && !pop) begin
                count_q <= count_q + CntWidth'(1);
            end else if (pop && !handshake) begin
                count_q <= count_q - CntWidth'(1);
            end

            if (handshake) begin
                lock_q <= 1'b0;
            end else if (s_req_o) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel;
            end

            spurious_q <= s_rvalid_i && empty;
        end
    end

`ifdef OBI_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_q <= 1'b0;
        end else if (handshake) begin
            last_q <= sel;
        end
    end
`endif

endmodule
